microwave_operation_control: RTL and testbench

//  Top-level sequencer for the level-1 microwave. It owns the EN_N input of

---
 rtl/microwave_operation_control_if.sv | 27 ++
 rtl/microwave_operation_control.sv | 158 +++++++++++++++
 tb/tb_microwave_operation_control.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/microwave_operation_control_if.sv
// microwave_operation_control_if: front-panel inputs and timer/magnetron outputs of the cook sequencer.
// Latency: none, plain wires bundled for port grouping.
// Backpressure: none; inputs are levels sampled by the sequencer, outputs are levels or one-cycle pulses.
interface microwave_operation_control_if;
    logic       start_n;
    logic       stop_n;
    logic       door_closed;
    logic       timer_zero;
    logic       kpad_en_n;
    logic       timer_en_n;
    logic       timer_clr_n;
    logic       mag_on;
    logic [1:0] state;
    logic       beep;

    // Front panel / timer side
    modport master (
        output start_n, stop_n, door_closed, timer_zero,
        input  kpad_en_n, timer_en_n, timer_clr_n, mag_on, state, beep
    );

    // Cook sequencer side
    modport slave (
        input  start_n, stop_n, door_closed, timer_zero,
        output kpad_en_n, timer_en_n, timer_clr_n, mag_on, state, beep
    );
endinterface

// File: rtl/microwave_operation_control.sv
// microwave_operation_control: 4-state cook sequencer (SET/COOK/PAUSE/DONE) driving keypad enable, timer and magnetron.
// Latency: button edge to STATE change is SYNC_STAGES+1 cycles; MAG_ON drops combinationally when the door opens.
// Backpressure: none; each button press yields one event, outputs are registered levels plus a one-cycle clear pulse.
// Optional done beeper is built only when MWAVE_DONE_BEEP_EN is defined; otherwise beep is tied low.
module microwave_operation_control #(
    parameter int SYNC_STAGES = 2,
    parameter int BEEP_CYCLES = 300
) (
    input  logic                          clk_100hz,
    input  logic                          clear_n,
    microwave_operation_control_if.slave  mw
);

    localparam logic [1:0] ST_SET   = 2'b00;
    localparam logic [1:0] ST_COOK  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    logic [SYNC_STAGES-1:0] start_sync;
    logic [SYNC_STAGES-1:0] stop_sync;
    logic [SYNC_STAGES-1:0] door_sync;
    logic                   start_prev;
    logic                   stop_prev;
    logic                   start_s;
    logic                   stop_s;
    logic                   door_s;
    logic                   start_evt;
    logic                   stop_evt;

    logic [1:0]             state_q;
    logic [1:0]             state_nxt;
    logic                   clr_req;
    logic                   kpad_en_n_q;
    logic                   timer_en_n_q;
    logic                   timer_clr_n_q;

    // Synchronizer chains; reset to the inactive level so no phantom press appears after reset
    always_ff @(posedge clk_100hz or negedge clear_n) begin
        if (!clear_n) begin
            start_sync <= '1;
            stop_sync  <= '1;
            door_sync  <= '0;
        end else begin
            start_sync <= {start_sync[SYNC_STAGES-2:0], mw.start_n};
            stop_sync  <= {stop_sync[SYNC_STAGES-2:0],  mw.stop_n};
            door_sync  <= {door_sync[SYNC_STAGES-2:0],  mw.door_closed};
        end
    end

    assign start_s = start_sync[SYNC_STAGES-1];
    assign stop_s  = stop_sync[SYNC_STAGES-1];
    assign door_s  = door_sync[SYNC_STAGES-1];

    // Previous synced button level for falling-edge detection
    always_ff @(posedge clk_100hz or negedge clear_n) begin
        if (!clear_n) begin
            start_prev <= 1'b1;
            stop_prev  <= 1'b1;
        end else begin
            start_prev <= start_s;
            stop_prev  <= stop_s;
        end
    end

    // A held button gives exactly one event: only the high-to-low transition counts
    assign start_evt = start_prev & ~start_s;
    assign stop_evt  = stop_prev  & ~stop_s;

    // Next-state logic; priority is timer zero, then door open, then stop, then start
    always_comb begin
        state_nxt = state_q;
        clr_req   = 1'b0;
        case (state_q)
            ST_SET: begin
                if (stop_evt) begin
                    clr_req = 1'b1;
                end else if (start_evt && door_s && !mw.timer_zero) begin
                    state_nxt = ST_COOK;
                end
            end
            ST_COOK: begin
                if (mw.timer_zero) begin
                    state_nxt = ST_DONE;
                end else if (!door_s || stop_evt) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop_evt) begin
                    state_nxt = ST_SET;
                    clr_req   = 1'b1;
                end else if (start_evt && door_s && !mw.timer_zero) begin
                    state_nxt = ST_COOK;
                end
            end
            ST_DONE: begin
                // Timer already reads zero, so returning to SET needs no clear
                if (start_evt || stop_evt || !door_s) begin
                    state_nxt = ST_SET;
                end
            end
            default: begin
                state_nxt = ST_SET;
            end
        endcase
    end

    // State register and Moore outputs registered from the next state so they align with STATE
    always_ff @(posedge clk_100hz or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= ST_SET;
            kpad_en_n_q   <= 1'b0;
            timer_en_n_q  <= 1'b1;
            timer_clr_n_q <= 1'b1;
        end else begin
            state_q       <= state_nxt;
            kpad_en_n_q   <= (state_nxt != ST_SET);
            timer_en_n_q  <= (state_nxt != ST_COOK);
            timer_clr_n_q <= ~clr_req;
        end
    end

    assign mw.state       = state_q;
    assign mw.kpad_en_n   = kpad_en_n_q;
    assign mw.timer_en_n  = timer_en_n_q;
    assign mw.timer_clr_n = timer_clr_n_q;

    // Raw door input kills the magnetron immediately, ahead of the synced PAUSE transition
    assign mw.mag_on = (state_q == ST_COOK) & mw.door_closed;

`ifdef MWAVE_DONE_BEEP_EN
    localparam logic [8:0] BEEP_LOAD = 9'(BEEP_CYCLES);

    logic [8:0] beep_cnt;

    // Beep countdown: load on DONE entry, count down while in DONE, clear on leaving DONE
    always_ff @(posedge clk_100hz or negedge clear_n) begin
        if (!clear_n) begin
            beep_cnt <= '0;
        end else if ((state_nxt == ST_DONE) && (state_q != ST_DONE)) begin
            beep_cnt <= BEEP_LOAD;
        end else if (state_nxt != ST_DONE) begin
            beep_cnt <= '0;
        end else if (beep_cnt != 9'd0) begin
            beep_cnt <= beep_cnt - 9'd1;
        end
    end

    assign mw.beep = (beep_cnt != 9'd0);
`else
    // Keeps the beep length parameter referenced in builds without the beeper
    logic [8:0] unused_beep_load;
    assign unused_beep_load = 9'(BEEP_CYCLES);

    assign mw.beep = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_operation_control.sv
// tb_microwave_operation_control: table vectors, corner sequences and randomized run against a reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_microwave_operation_control;

    localparam int SYNC     = 2;
    localparam int BEEP_CYC = 300;
`ifdef MWAVE_DONE_BEEP_EN
    localparam bit BEEP_ON = 1'b1;
`else
    localparam bit BEEP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic clear_n;

    always #5 clk = ~clk;

    microwave_operation_control_if mw_if();

    microwave_operation_control #(
        .SYNC_STAGES (SYNC),
        .BEEP_CYCLES (BEEP_CYC)
    ) dut (
        .clk_100hz (clk),
        .clear_n   (clear_n),
        .mw        (mw_if)
    );

    typedef struct {
        logic       s, p, d, t;
        logic [1:0] st;
        logic       cl, mg, bp;
    } vec_t;

    vec_t tbl[42];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: button/door histories as delay lines, cook rules applied per edge
    int   m_state;
    bit   m_clr;
    int   m_age;
    bit   st_h[$];
    bit   sp_h[$];
    bit   dr_h[$];

    function automatic vec_t mk(logic s, logic p, logic d, logic t,
                                logic [1:0] st, logic cl, logic mg, logic bp);
        vec_t v;
        v.s = s; v.p = p; v.d = d; v.t = t;
        v.st = st; v.cl = cl; v.mg = mg; v.bp = bp;
        return v;
    endfunction

    // Output vector order: state, kpad_en_n, timer_en_n, timer_clr_n, mag_on, beep
    function automatic logic [6:0] dut_out();
        return {mw_if.state, mw_if.kpad_en_n, mw_if.timer_en_n,
                mw_if.timer_clr_n, mw_if.mag_on, mw_if.beep};
    endfunction

    function automatic logic [6:0] exp_of(logic [1:0] st, logic cl, logic mg, logic bp);
        return {st, st != 2'b00, st != 2'b01, cl, mg, bp};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic p, input logic d, input logic t);
        mw_if.start_n     = s;
        mw_if.stop_n      = p;
        mw_if.door_closed = d;
        mw_if.timer_zero  = t;
    endtask

    task automatic cyc(input logic s, input logic p, input logic d, input logic t);
        drive(s, p, d, t);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_clr   = 1'b0;
        m_age   = 0;
        st_h.delete(); sp_h.delete(); dr_h.delete();
        for (int i = 0; i < SYNC + 1; i++) begin
            st_h.push_back(1'b1);
            sp_h.push_back(1'b1);
            dr_h.push_back(1'b0);
        end
    endtask

    task automatic model_edge(input bit s, input bit p, input bit d, input bit t);
        bit st_evt, sp_evt, door_ok;
        int nxt;
        st_evt  = st_h[0] && !st_h[1];
        sp_evt  = sp_h[0] && !sp_h[1];
        door_ok = dr_h[1];
        nxt     = m_state;
        m_clr   = 1'b0;
        case (m_state)
            0: if (sp_evt) m_clr = 1'b1;
               else if (st_evt && door_ok && !t) nxt = 1;
            1: if (t) nxt = 3;
               else if (!door_ok || sp_evt) nxt = 2;
            2: if (sp_evt) begin nxt = 0; m_clr = 1'b1; end
               else if (st_evt && door_ok && !t) nxt = 1;
            default: if (st_evt || sp_evt || !door_ok) nxt = 0;
        endcase
        if (nxt == 3 && m_state != 3) m_age = 0;
        else if (nxt == 3) m_age++;
        m_state = nxt;
        st_h.push_back(s); void'(st_h.pop_front());
        sp_h.push_back(p); void'(sp_h.pop_front());
        dr_h.push_back(d); void'(dr_h.pop_front());
    endtask

    function automatic logic [6:0] model_out(logic door_raw);
        logic bp;
        bp = BEEP_ON && (m_state == 3) && (m_age < BEEP_CYC);
        return exp_of(2'(m_state), !m_clr, (m_state == 1) && door_raw, bp);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beeps;
        logic rs, rp, rd, rt;

        // Hand-derived vectors: {start_n, stop_n, door, timer_zero} -> {state, clr_n, mag_on, beep}
        tbl[0]  = mk(1,1,1,0, 2'd0, 1,0,0);
        tbl[1]  = mk(1,1,1,0, 2'd0, 1,0,0);
        tbl[2]  = mk(1,1,1,0, 2'd0, 1,0,0);
        tbl[3]  = mk(0,1,1,0, 2'd0, 1,0,0);
        tbl[4]  = mk(0,1,1,0, 2'd0, 1,0,0);
        tbl[5]  = mk(0,1,1,0, 2'd1, 1,1,0);
        tbl[6]  = mk(0,1,1,0, 2'd1, 1,1,0);
        tbl[7]  = mk(0,1,1,0, 2'd1, 1,1,0);
        tbl[8]  = mk(1,1,1,0, 2'd1, 1,1,0);
        tbl[9]  = mk(1,1,1,0, 2'd1, 1,1,0);
        tbl[10] = mk(1,1,0,0, 2'd1, 1,0,0);
        tbl[11] = mk(1,1,0,0, 2'd1, 1,0,0);
        tbl[12] = mk(1,1,0,0, 2'd2, 1,0,0);
        tbl[13] = mk(1,1,1,0, 2'd2, 1,0,0);
        tbl[14] = mk(1,1,1,0, 2'd2, 1,0,0);
        tbl[15] = mk(0,1,1,0, 2'd2, 1,0,0);
        tbl[16] = mk(0,1,1,0, 2'd2, 1,0,0);
        tbl[17] = mk(0,1,1,0, 2'd1, 1,1,0);
        tbl[18] = mk(1,1,1,0, 2'd1, 1,1,0);
        tbl[19] = mk(1,0,1,0, 2'd1, 1,1,0);
        tbl[20] = mk(1,0,1,0, 2'd1, 1,1,0);
        tbl[21] = mk(1,1,1,0, 2'd2, 1,0,0);
        tbl[22] = mk(1,1,1,0, 2'd2, 1,0,0);
        tbl[23] = mk(1,0,1,0, 2'd2, 1,0,0);
        tbl[24] = mk(1,0,1,0, 2'd2, 1,0,0);
        tbl[25] = mk(1,1,1,0, 2'd0, 0,0,0);
        tbl[26] = mk(1,1,1,0, 2'd0, 1,0,0);
        tbl[27] = mk(0,1,1,1, 2'd0, 1,0,0);
        tbl[28] = mk(0,1,1,1, 2'd0, 1,0,0);
        tbl[29] = mk(1,1,1,1, 2'd0, 1,0,0);
        tbl[30] = mk(1,1,1,0, 2'd0, 1,0,0);
        tbl[31] = mk(0,1,1,0, 2'd0, 1,0,0);
        tbl[32] = mk(0,1,1,0, 2'd0, 1,0,0);
        tbl[33] = mk(1,1,1,0, 2'd1, 1,1,0);
        tbl[34] = mk(1,0,1,0, 2'd1, 1,1,0);
        tbl[35] = mk(1,0,1,0, 2'd1, 1,1,0);
        tbl[36] = mk(1,1,1,1, 2'd3, 1,0,BEEP_ON);
        tbl[37] = mk(1,1,1,1, 2'd3, 1,0,BEEP_ON);
        tbl[38] = mk(0,1,1,1, 2'd3, 1,0,BEEP_ON);
        tbl[39] = mk(0,1,1,1, 2'd3, 1,0,BEEP_ON);
        tbl[40] = mk(1,1,1,1, 2'd0, 1,0,0);
        tbl[41] = mk(1,1,1,0, 2'd0, 1,0,0);

        // Reset values
        clear_n = 1'b0;
        drive(1, 1, 1, 0);
        repeat (3) @(negedge clk);
        check("reset_hold", dut_out(), exp_of(2'd0, 1, 0, 0));
        clear_n = 1'b1;
        @(negedge clk);
        check("reset_release", dut_out(), exp_of(2'd0, 1, 0, 0));

        // Table vectors
        for (int i = 0; i < 42; i++) begin
            cyc(tbl[i].s, tbl[i].p, tbl[i].d, tbl[i].t);
            check($sformatf("row%0d", i), dut_out(),
                  exp_of(tbl[i].st, tbl[i].cl, tbl[i].mg, tbl[i].bp));
        end

        // Simultaneous start and stop in PAUSE resolves as stop with a clear pulse
        cyc(0,1,1,0); cyc(0,1,1,0); cyc(1,1,1,0);
        check("both_cook", mw_if.state, 2'd1);
        cyc(1,0,1,0); cyc(1,0,1,0); cyc(1,1,1,0);
        check("both_pause", mw_if.state, 2'd2);
        cyc(0,0,1,0); cyc(0,0,1,0); cyc(1,1,1,0);
        check("both_set", mw_if.state, 2'd0);
        check("both_clr_low", mw_if.timer_clr_n, 1'b0);
        cyc(1,1,1,0);
        check("both_clr_high", mw_if.timer_clr_n, 1'b1);

        // Full beep length in DONE, then stop returns to SET without a clear
        cyc(0,1,1,0); cyc(0,1,1,0); cyc(1,1,1,0);
        check("beep_cook", mw_if.state, 2'd1);
        cyc(1,1,1,1);
        check("beep_done", mw_if.state, 2'd3);
        beeps = int'(mw_if.beep);
        for (int i = 0; i < 319; i++) begin
            cyc(1,1,1,1);
            beeps += int'(mw_if.beep);
        end
        check("beep_len", beeps, BEEP_ON ? BEEP_CYC : 0);
        check("beep_end", mw_if.beep, 1'b0);
        cyc(1,0,1,1); cyc(1,0,1,1); cyc(1,1,1,0);
        check("done_stop_state", mw_if.state, 2'd0);
        check("done_stop_noclr", mw_if.timer_clr_n, 1'b1);

        // Door open leaves DONE early and silences the beeper
        cyc(0,1,1,0); cyc(0,1,1,0); cyc(1,1,1,0);
        cyc(1,1,1,1);
        check("early_beep", mw_if.beep, BEEP_ON);
        cyc(1,1,0,1); cyc(1,1,0,1);
        check("early_still_done", mw_if.state, 2'd3);
        cyc(1,1,0,1);
        check("early_set", dut_out(), exp_of(2'd0, 1, 0, 0));
        cyc(1,1,1,0); cyc(1,1,1,0);

        // Mid-cycle asynchronous reset while cooking
        cyc(0,1,1,0); cyc(0,1,1,0); cyc(1,1,1,0);
        check("pre_clear_mag", mw_if.mag_on, 1'b1);
        #2 clear_n = 1'b0;
        #1 check("async_clear", dut_out(), exp_of(2'd0, 1, 0, 0));
        @(posedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        model_reset();

        // Randomized run against the reference model
        rs = 1'b1; rp = 1'b1; rd = 1'b1; rt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 20) rs = ~rs;
            if ($urandom_range(0, 99) < 12) rp = ~rp;
            if ($urandom_range(0, 99) < 6)  rd = ~rd;
            if ($urandom_range(0, 99) < 6)  rt = ~rt;
            drive(rs, rp, rd, rt);
            @(posedge clk);
            model_edge(rs, rp, rd, rt);
            @(negedge clk);
            check($sformatf("rand%0d", i), dut_out(), model_out(rd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
